// File: rtl/if_prefetch.sv
// Instruction prefetch queue: issues one fetch per cycle into a 1-cycle memory and
// buffers {PC, word} pairs for the decode stage. A branch flushes the queue and any in-flight response.
module if_prefetch #(
   parameter int PC_SIZE = 10,
   parameter int DEPTH   = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       imem_en,
   output logic [PC_SIZE-1:0]         imem_addr,
   input  logic [31:0]                imem_data,
   input  logic                       branch_taken,
   input  logic [PC_SIZE-1:0]         branch_target,
   input  logic                       id_ready,
   output logic                       id_valid,
   output logic [31:0]                instruction,
   output logic [PC_SIZE-1:0]         PC_out,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [PC_SIZE-1:0] pc_q, pc_d;
   logic [PC_SIZE-1:0] fl_pc_q, fl_pc_d;
   logic               fl_q, fl_d;
   logic [AW-1:0]      wr_q, wr_d;
   logic [AW-1:0]      rd_q, rd_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PC_SIZE+31:0] mem_q [DEPTH];

   logic [CW:0]        occ;
   logic               push;
   logic               pop;
   logic [PC_SIZE+31:0] head;

   always_comb begin
      // Occupancy counts the in-flight slot so a response always has room to land.
      occ     = {1'b0, cnt_q} + {{CW{1'b0}}, fl_q};
      imem_en = !reset && !branch_taken && (occ < DEPTH_W);
      push    = fl_q && !branch_taken && !reset;
      pop     = (cnt_q != '0) && id_ready && !branch_taken && !reset;

      pc_d    = pc_q;
      fl_d    = imem_en;
      fl_pc_d = fl_pc_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;

      if (imem_en) begin
         pc_d    = pc_q + PC_SIZE'(4);
         fl_pc_d = pc_q;
      end
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      if (branch_taken) begin
         pc_d  = branch_target;
         fl_d  = 1'b0;
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q    <= '0;
         fl_pc_q <= '0;
         fl_q    <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         fl_pc_q <= fl_pc_d;
         fl_q    <= fl_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q] <= {fl_pc_q, imem_data};
   end

   assign head        = mem_q[rd_q];
   assign imem_addr   = pc_q;
   assign fifo_count  = cnt_q;
   assign id_valid    = (cnt_q != '0) && !reset;
   assign instruction = id_valid ? head[31:0] : NOP;
   assign PC_out      = id_valid ? head[PC_SIZE+31:32] : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed phases push expected PCs into a scoreboard queue,
// a negedge monitor compares every accepted instruction against it.
module tb_if_prefetch;

   localparam int PC_SIZE = 10;
   localparam int DEPTH   = 4;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 imem_en;
   logic [PC_SIZE-1:0]   imem_addr;
   logic [31:0]          imem_data = 32'h0;
   logic                 branch_taken;
   logic [PC_SIZE-1:0]   branch_target;
   logic                 id_ready;
   logic                 id_valid;
   logic [31:0]          instruction;
   logic [PC_SIZE-1:0]   PC_out;
   logic [$clog2(DEPTH):0] fifo_count;

   int tests = 0;
   int fails = 0;
   int exp_q[$];

   if_prefetch #(.PC_SIZE(PC_SIZE), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_data(imem_data), .branch_taken(branch_taken), .branch_target(branch_target),
      .id_ready(id_ready), .id_valid(id_valid), .instruction(instruction),
      .PC_out(PC_out), .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] tag(input int addr);
      return 32'hA500_0000 | (addr & 32'h3FF);
   endfunction

   always @(posedge clock) begin
      if (imem_en) imem_data <= tag(int'(imem_addr));
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_seq(input int start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back((start + 4*i) & 32'h3FF);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (!reset && !branch_taken && id_valid && id_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mon_extra: got pc 0x%0h expected no delivery at %0t", PC_out, $time);
         end else begin
            int e;
            e = exp_q.pop_front();
            chk("mon_pc", int'(PC_out), e);
            chk("mon_instr", int'(instruction), int'(tag(e)));
         end
      end
   end

   initial begin
      bit found;
      reset = 1'b1; branch_taken = 1'b0; branch_target = '0; id_ready = 1'b1;
      step(); step();
      chk("rst_imem_en", int'(imem_en), 0);
      chk("rst_id_valid", int'(id_valid), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_instr", int'(instruction), 32'h13);
      chk("rst_pc_out", int'(PC_out), 0);

      // streaming from reset release
      push_seq(0, 40);
      reset = 1'b0;
      #1;
      for (int k = 0; k < 10; k++) begin
         chk("stream_addr", int'(imem_addr), 4*k);
         chk("stream_en", int'(imem_en), 1);
         if (k < 2) chk("stream_nvalid", int'(id_valid), 0);
         else       chk("stream_pc", int'(PC_out), 4*(k-2));
         step();
      end

      // branch flush to 0x100
      branch_taken = 1'b1; branch_target = 10'h100;
      exp_q.delete(); push_seq(32'h100, 20);
      #1 chk("br_en", int'(imem_en), 0);
      step();
      branch_taken = 1'b0;
      #1;
      chk("br_count", int'(fifo_count), 0);
      chk("br_valid", int'(id_valid), 0);
      chk("br_instr", int'(instruction), 32'h13);
      chk("br_pc_out", int'(PC_out), 0);
      chk("br_addr", int'(imem_addr), 32'h100);
      chk("br_en2", int'(imem_en), 1);
      step(); chk("br_lat1", int'(id_valid), 0);
      step(); chk("br_lat2", int'(id_valid), 1);
      chk("br_first_pc", int'(PC_out), 32'h100);
      for (int k = 0; k < 4; k++) step();

      // PC wrap at top of address space
      branch_taken = 1'b1; branch_target = 10'h3F8;
      exp_q.delete(); push_seq(32'h3F8, 20);
      #1 chk("wrap_br_en", int'(imem_en), 0);
      step(); branch_taken = 1'b0;
      #1 chk("wrap_a0", int'(imem_addr), 32'h3F8);
      step(); chk("wrap_a1", int'(imem_addr), 32'h3FC);
      step(); chk("wrap_a2", int'(imem_addr), 0);
      chk("wrap_en", int'(imem_en), 1);
      for (int k = 0; k < 6; k++) step();

      // back-to-back branches: last target wins
      branch_taken = 1'b1; branch_target = 10'h040; exp_q.delete();
      #1 chk("bb_en1", int'(imem_en), 0);
      step();
      branch_target = 10'h080; exp_q.delete(); push_seq(32'h80, 20);
      #1 chk("bb_en2", int'(imem_en), 0);
      step(); branch_taken = 1'b0;
      #1 chk("bb_addr", int'(imem_addr), 32'h80);
      for (int k = 0; k < 6; k++) step();

      // backpressure from reset
      reset = 1'b1; id_ready = 1'b0; exp_q.delete();
      step();
      reset = 1'b0; push_seq(0, 40);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("bp_en", int'(imem_en), 1);
         chk("bp_addr", int'(imem_addr), 4*k);
         step();
      end
      chk("bp_stall", int'(imem_en), 0);
      step();
      chk("bp_full", int'(fifo_count), 4);
      chk("bp_stall2", int'(imem_en), 0);
      chk("bp_head", int'(PC_out), 0);
      chk("bp_head_instr", int'(instruction), int'(tag(0)));
      step();
      chk("bp_hold", int'(PC_out), 0);
      chk("bp_full2", int'(fifo_count), 4);
      id_ready = 1'b1;
      for (int k = 0; k < 8; k++) step();

      // reset while nearly full with a request in flight
      id_ready = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (fifo_count == 3 && !imem_en) found = 1'b1;
      end
      if (!found) begin
         tests++; fails++;
         $display("FAIL rst_mid_wait: got no full+inflight state expected one within 10 cycles");
      end
      reset = 1'b1; exp_q.delete();
      #1;
      chk("rm_en", int'(imem_en), 0);
      chk("rm_valid", int'(id_valid), 0);
      step();
      chk("rm_count", int'(fifo_count), 0);
      chk("rm_valid2", int'(id_valid), 0);
      step();
      reset = 1'b0; id_ready = 1'b1; push_seq(0, 20);
      #1;
      chk("rm_addr", int'(imem_addr), 0);
      chk("rm_en2", int'(imem_en), 1);
      chk("rm_nvalid", int'(id_valid), 0);
      step(); chk("rm_nvalid2", int'(id_valid), 0);
      step(); chk("rm_valid3", int'(id_valid), 1);
      chk("rm_first_pc", int'(PC_out), 0);
      for (int k = 0; k < 4; k++) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter PC_SIZE, default 10, meaning the width of the byte-address program counter.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of prefetch queue entries (power of two, at least 2).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_en  output  1  instruction memory read request this cycle.
REQ-006 SHALL have port imem_addr  output  PC_SIZE  byte address of the request.
REQ-007 SHALL have port imem_data  input  32  read data, valid in the cycle after the request (1-cycle synchronous memory).
REQ-008 SHALL have port branch_taken  input  1  redirect/flush pulse from the decode/execute side.
REQ-009 SHALL have port branch_target  input  PC_SIZE  redirect byte address, sampled when branch_taken=1.
REQ-010 SHALL have port id_ready  input  1  decode stage accepts the head instruction this cycle.
REQ-011 SHALL have port id_valid  output  1  instruction/PC_out hold a valid queue head.
REQ-012 SHALL have port instruction  output  32  queue-head instruction word, feeding the decode stage.
REQ-013 SHALL have port PC_out  output  PC_SIZE  byte address of the queue-head instruction.
REQ-014 SHALL have port fifo_count  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 SHALL keep a fetch PC; each issued request uses imem_addr=fetch PC, then fetch PC advances by 4 modulo 2^PC_SIZE (wrap from max to low addresses, no error).
REQ-016 SHALL assert imem_en only when reset=0, branch_taken=0, and fifo_count + in-flight (0 or 1) < DEPTH; a same-cycle pop does not relax this check.
REQ-017 SHALL hold at most one request in flight; the response is pushed as {PC, imem_data} at the end of the cycle after the request.
REQ-018 SHALL achieve one request per cycle with id_ready held 1: steady state fifo_count=1, one in flight.
REQ-019 SHALL pop the head when id_valid=1 and id_ready=1; push and pop in the same cycle leave fifo_count unchanged.
REQ-020 SHALL drive id_valid=1 exactly when fifo_count>0; when id_valid=0, instruction SHALL be 32'h00000013 (NOP) and PC_out SHALL be 0.
REQ-021 SHALL present instruction/PC_out combinationally from the head entry; head stable while id_valid=1 and id_ready=0.
REQ-022 SHALL never overflow: a push into a full queue is impossible by REQ-016; a pop on an empty queue is ignored.
REQ-023 SHALL treat branch_taken=1 as highest priority: in that cycle imem_en=0, no push, no pop; at the edge, queue cleared (fifo_count=0), any in-flight response squashed (its data next cycle is discarded), fetch PC := branch_target.
REQ-024 SHALL issue the target request in the cycle after branch_taken (if branch_taken is then 0); first target instruction appears with id_valid=1 two cycles after that request.
REQ-025 SHALL let back-to-back branch_taken pulses each re-flush; the last target wins.
REQ-026 SHALL ignore branch_target alignment; low two bits are used as given.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, set fetch PC=0, fifo_count=0, in-flight=0, queue pointers=0; during reset cycles imem_en=0 and id_valid=0.
REQ-028 SHALL take reset over branch_taken and all other inputs, including mid-operation; an in-flight response arriving after reset is discarded.
REQ-029 SHALL issue the first request (imem_addr=0) in the first cycle with reset=0.

Verification
REQ-030 Reset release, id_ready=1, memory returns addr-tagged words -> imem_addr 0,4,8,... every cycle; id_valid first high 2 cycles after first request with PC_out=0; then one instruction per cycle in order.
REQ-031 id_ready=0 from reset -> four requests (0,4,8,12), fifo_count reaches 4, imem_en stays 0; head PC_out=0 stable; raising id_ready drains in order with refill.
REQ-032 Steady stream, branch_taken=1 with target 0x100 -> that cycle imem_en=0; next cycle fifo_count=0, id_valid=0, instruction=0x00000013, imem_addr=0x100; old in-flight word never delivered.
REQ-033 Fetch PC at 2^PC_SIZE-4 (0x3FC) -> next imem_addr 0x000, no stall.
REQ-034 Reset asserted with queue full and request in flight -> next cycle fifo_count=0, id_valid=0; after release first imem_addr=0.
REQ-035 branch_taken on two consecutive cycles (targets 0x40 then 0x80) -> only 0x80 fetched; no instruction from 0x40 or earlier delivered.
